// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types, error codes, default timing and parity helper for the
// PS/2 host transmitter (and reusable by the receive path).
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        WAIT_START,
        SEND,
        ACK,
        WAIT_IDLE,
        ERR
    } ps2_state_t;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_START_TO = 2'd1;
    localparam logic [1:0] ERR_PKT_TO   = 2'd2;
    localparam logic [1:0] ERR_NACK     = 2'd3;

    // Default timing, expressed in physical units and scaled by the clock rate
    localparam int unsigned DEF_CLK_FREQ_HZ = 100_000_000;
    localparam int unsigned DEF_INHIBIT_US  = 120;
    localparam int unsigned DEF_START_TO_MS = 15;
    localparam int unsigned DEF_PKT_TO_MS   = 2;

    // Parity bit that makes the 9-bit {parity, data} word carry an odd number of ones
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: 2-FF synchronizer for one raw PS/2 line plus a falling-edge
// detector on the synchronized level. Lines idle high, so reset preloads ones
// to avoid a spurious fall right after reset.
module ps2_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic line_in,
    output logic level,
    output logic fall
);

    // [0],[1] form the synchronizer; [2] holds the previous synced level
    logic [2:0] sync_pipe;

    // Shift the raw line through the synchronizer and edge-history stages
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_pipe <= 3'b111;
        else     sync_pipe <= {sync_pipe[1:0], line_in};
    end

    assign level = sync_pipe[1];
    assign fall  = sync_pipe[2] & ~sync_pipe[1];

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: sends one command byte host-to-device on an open-drain PS/2 bus.
// Frame on the wire: start 0, d0..d7, odd parity, stop 1, then device ACK.
// Optional build macro PS2_TX_RETRY_EN: after a packet timeout or NACK the
// same byte is retried once from INHIBIT before an error is reported.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ    = DEF_CLK_FREQ_HZ,
    parameter int unsigned INHIBIT_CYCLES = CLK_FREQ_HZ / 1_000_000 * DEF_INHIBIT_US,
    parameter int unsigned START_TIMEOUT  = CLK_FREQ_HZ / 1_000 * DEF_START_TO_MS,
    parameter int unsigned PACKET_TIMEOUT = CLK_FREQ_HZ / 1_000 * DEF_PKT_TO_MS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err,
    output logic [1:0] err_code
);

    localparam int unsigned TMAX0 = (INHIBIT_CYCLES > START_TIMEOUT) ? INHIBIT_CYCLES : START_TIMEOUT;
    localparam int unsigned TMAX  = (TMAX0 > PACKET_TIMEOUT) ? TMAX0 : PACKET_TIMEOUT;
    localparam int          TW    = $clog2(TMAX);

    // Terminal values: the last cycle of each window, so counters never wrap
    localparam logic [TW-1:0] INH_LAST   = TW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] START_LAST = TW'(START_TIMEOUT - 1);
    localparam logic [TW-1:0] PKT_LAST   = TW'(PACKET_TIMEOUT - 1);

    ps2_state_t    state, state_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic [3:0]    bit_cnt, bit_cnt_nxt;
    logic          cur_bit, cur_bit_nxt;
    logic [9:0]    frame, frame_nxt;
    logic [1:0]    err_nxt;
    logic          retried, retried_nxt;
    logic          fail;
    logic [1:0]    fail_code;

    logic clk_lvl, clk_fall, data_lvl, data_fall_unused;

    ps2_line_sync u_clk_sync (
        .clk     (clk),
        .rst     (rst),
        .line_in (ps2_clk_in),
        .level   (clk_lvl),
        .fall    (clk_fall)
    );

    ps2_line_sync u_data_sync (
        .clk     (clk),
        .rst     (rst),
        .line_in (ps2_data_in),
        .level   (data_lvl),
        .fall    (data_fall_unused)
    );

    assign busy = (state != IDLE);

    // State and datapath registers; reset releases both lines immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            timer    <= '0;
            bit_cnt  <= '0;
            cur_bit  <= 1'b1;
            frame    <= '0;
            err_code <= ERR_NONE;
            retried  <= 1'b0;
        end else begin
            state    <= state_nxt;
            timer    <= timer_nxt;
            bit_cnt  <= bit_cnt_nxt;
            cur_bit  <= cur_bit_nxt;
            frame    <= frame_nxt;
            err_code <= err_nxt;
            retried  <= retried_nxt;
        end
    end

    // Next-state, line drive and status pulses; timeouts are checked before falls
    always_comb begin
        state_nxt   = state;
        timer_nxt   = timer;
        bit_cnt_nxt = bit_cnt;
        cur_bit_nxt = cur_bit;
        frame_nxt   = frame;
        err_nxt     = err_code;
        retried_nxt = retried;
        tx_ready    = 1'b0;
        ps2_clk_oe  = 1'b0;
        ps2_data_oe = 1'b0;
        tx_done     = 1'b0;
        tx_err      = 1'b0;
        fail        = 1'b0;
        fail_code   = ERR_NONE;

        unique case (state)
            IDLE: begin
                tx_ready = 1'b1;
                if (tx_valid) begin
                    frame_nxt   = {1'b1, odd_parity(tx_data), tx_data};
                    err_nxt     = ERR_NONE;
                    retried_nxt = 1'b0;
                    timer_nxt   = '0;
                    bit_cnt_nxt = '0;
                    state_nxt   = INHIBIT;
                end
            end
            INHIBIT: begin
                ps2_clk_oe = 1'b1;
                if (timer == INH_LAST) begin
                    timer_nxt = '0;
                    state_nxt = RTS;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            RTS: begin
                ps2_clk_oe  = 1'b1;
                ps2_data_oe = 1'b1;
                state_nxt   = WAIT_START;
            end
            WAIT_START: begin
                ps2_data_oe = 1'b1;
                if (timer == START_LAST) begin
                    fail      = 1'b1;
                    fail_code = ERR_START_TO;
                end else if (clk_fall) begin
                    cur_bit_nxt = frame[0];
                    bit_cnt_nxt = 4'd1;
                    timer_nxt   = '0;
                    state_nxt   = SEND;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            SEND: begin
                ps2_data_oe = ~cur_bit;
                if (timer == PKT_LAST) begin
                    fail      = 1'b1;
                    fail_code = ERR_PKT_TO;
                end else begin
                    timer_nxt = timer + TW'(1);
                    if (clk_fall) begin
                        cur_bit_nxt = frame[bit_cnt];
                        bit_cnt_nxt = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd9) state_nxt = ACK;
                    end
                end
            end
            ACK: begin
                if (timer == PKT_LAST) begin
                    fail      = 1'b1;
                    fail_code = ERR_PKT_TO;
                end else begin
                    timer_nxt = timer + TW'(1);
                    if (clk_fall) begin
                        if (data_lvl) begin
                            fail      = 1'b1;
                            fail_code = ERR_NACK;
                        end else begin
                            state_nxt = WAIT_IDLE;
                        end
                    end
                end
            end
            WAIT_IDLE: begin
                if (timer == PKT_LAST) begin
                    fail      = 1'b1;
                    fail_code = ERR_PKT_TO;
                end else begin
                    timer_nxt = timer + TW'(1);
                    if (clk_lvl && data_lvl) begin
                        tx_done   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            ERR: begin
                tx_err    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

`ifdef PS2_TX_RETRY_EN
        if (fail && (fail_code != ERR_START_TO) && !retried) begin
            retried_nxt = 1'b1;
            timer_nxt   = '0;
            bit_cnt_nxt = '0;
            state_nxt   = INHIBIT;
        end else if (fail) begin
            err_nxt   = fail_code;
            state_nxt = ERR;
        end
`else
        if (fail) begin
            err_nxt   = fail_code;
            state_nxt = ERR;
        end
`endif
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed vectors against a behavioural PS/2 device on a
// wired-AND bus. Timing parameters are scaled down to keep runs short.
module tb_ps2_host_tx;

    localparam int INH = 120;
    localparam int STO = 1500;
    localparam int PTO = 2000;
    localparam int H   = 20;   // device clock half period in system cycles

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, tx_done, tx_err;
    logic [1:0] err_code;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       ps2_clk_in, ps2_data_in;

    assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    always #5 clk = ~clk;

    ps2_host_tx #(
        .CLK_FREQ_HZ   (1_000_000),
        .INHIBIT_CYCLES(INH),
        .START_TIMEOUT (STO),
        .PACKET_TIMEOUT(PTO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .busy       (busy),
        .tx_done    (tx_done),
        .tx_err     (tx_err),
        .err_code   (err_code)
    );

    int errors = 0;
    int checks = 0;

    // Event counters, written only by the monitor below
    int done_cnt = 0, err_cnt = 0, both_cnt = 0, inh_cnt = 0, rts_cnt = 0;
    int ws_cnt = 0, drop_cnt = 0;
    logic [1:0] code_at_err = 2'd0;
    logic [1:0] oe_at_err = 2'd0;
    logic busy_q = 1'b0;

    always @(negedge clk) begin
        if (tx_done) done_cnt++;
        if (tx_err) begin
            err_cnt++;
            code_at_err = err_code;
            oe_at_err   = {ps2_clk_oe, ps2_data_oe};
        end
        if (tx_done && tx_err) both_cnt++;
        if (ps2_clk_oe && !ps2_data_oe) inh_cnt++;
        if (ps2_clk_oe && ps2_data_oe) rts_cnt++;
        if (busy && !ps2_clk_oe && ps2_data_oe) ws_cnt++;
        if (busy_q && !busy) drop_cnt++;
        busy_q = busy;
    end

    typedef struct {
        logic [7:0]  data;
        int          nfall;     // device falls per attempt (11 = full frame + ACK)
        bit          ack1;      // ACK on first attempt
        bit          ack2;      // ACK on retry attempt
        bit          poke;      // pulse tx_valid=0x55 while busy
        int          tries;     // attempts the host is expected to make
        bit          exp_done;
        logic [1:0]  exp_code;
        logic [10:0] exp_bits;  // {stop, parity, d7..d0, start}
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Wait for inhibit followed by request-to-send (clock released, data low)
    task automatic wait_rts(output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        while (!ps2_clk_oe) begin
            @(negedge clk); n++;
            if (n > 5000) return;
        end
        while (!(!ps2_clk_oe && ps2_data_oe)) begin
            @(negedge clk); n++;
            if (n > 5000) return;
        end
        ok = 1'b1;
    endtask

    // Device clocks nfall falling edges, sampling the line on each rising edge
    task automatic device_clock(input int nfall, input bit ack, output logic [10:0] bits);
        bits = '0;
        repeat (H) @(negedge clk);
        bits[0] = ps2_data_in;
        for (int i = 1; i <= nfall && i <= 10; i++) begin
            dev_clk = 1'b0;
            repeat (H) @(negedge clk);
            bits[i] = ps2_data_in;
            dev_clk = 1'b1;
            repeat (H) @(negedge clk);
        end
        if (nfall == 11) begin
            dev_data = ack ? 1'b0 : 1'b1;
            repeat (4) @(negedge clk);
            dev_clk = 1'b0;
            repeat (H) @(negedge clk);
            dev_clk = 1'b1;
            repeat (4) @(negedge clk);
            dev_data = 1'b1;
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 10000; n++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_vec(input vec_t v);
        int d0, e0, i0, r0, w0, b0;
        logic [10:0] bits;
        bit ok;
        @(negedge clk);
        d0 = done_cnt; e0 = err_cnt; i0 = inh_cnt; r0 = rts_cnt; w0 = ws_cnt; b0 = drop_cnt;
        chk("ready_before", tx_ready, 1);
        tx_valid = 1'b1;
        tx_data  = v.data;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        chk("busy_after_accept", busy, 1);
        chk("code_cleared", err_code, 0);
        if (v.poke) begin
            repeat (10) @(negedge clk);
            chk("ready_while_busy", tx_ready, 0);
            tx_valid = 1'b1;
            tx_data  = 8'h55;
            repeat (3) @(negedge clk);
            tx_valid = 1'b0;
            tx_data  = 8'h00;
        end
        for (int t = 0; t < v.tries; t++) begin
            wait_rts(ok);
            chk("rts_seen", ok, 1);
            if (ok && v.nfall > 0) begin
                device_clock(v.nfall, (t == 0) ? v.ack1 : v.ack2, bits);
                if (v.nfall == 11) chk("line_bits", bits, v.exp_bits);
            end
        end
        wait_idle(ok);
        chk("back_to_idle", ok, 1);
        repeat (2) @(negedge clk);
        chk("done_pulses", done_cnt - d0, v.exp_done);
        chk("err_pulses", err_cnt - e0, !v.exp_done);
        chk("err_code", err_code, v.exp_code);
        if (!v.exp_done) begin
            chk("code_at_err", code_at_err, v.exp_code);
            chk("oe_at_err", oe_at_err, 0);
        end
        chk("inhibit_cycles", inh_cnt - i0, INH * v.tries);
        chk("rts_cycles", rts_cnt - r0, v.tries);
        chk("busy_drops", drop_cnt - b0, 1);
        if (v.nfall == 0) chk("wait_start_cycles", ws_cnt - w0, STO);
        chk("ready_after", tx_ready, 1);
        chk("oe_after", {ps2_clk_oe, ps2_data_oe}, 0);
    endtask

    initial begin
        logic [10:0] bits;
        bit ok;
        vec_t va;

        //          data   nf  a1 a2 pk tr done code  bits
        vecs[0] = '{8'hED, 11, 1, 1, 0, 1, 1, 2'd0, 11'b11_11101101_0};
        vecs[1] = '{8'h01, 11, 1, 1, 0, 1, 1, 2'd0, 11'b10_00000001_0};
        vecs[2] = '{8'hFF,  0, 0, 0, 0, 1, 0, 2'd1, 11'b0};
`ifdef PS2_TX_RETRY_EN
        vecs[3] = '{8'hF4,  5, 0, 0, 0, 2, 0, 2'd2, 11'b0};
        vecs[4] = '{8'h00, 11, 0, 1, 0, 2, 1, 2'd0, 11'b11_00000000_0};
`else
        vecs[3] = '{8'hF4,  5, 0, 0, 0, 1, 0, 2'd2, 11'b0};
        vecs[4] = '{8'h00, 11, 0, 1, 0, 1, 0, 2'd3, 11'b11_00000000_0};
`endif
        vecs[5] = '{8'h12, 11, 1, 1, 1, 1, 1, 2'd0, 11'b11_00010010_0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
        chk("rst_done", tx_done, 0);
        chk("rst_err", tx_err, 0);
        chk("rst_err_code", err_code, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Reset in the middle of SEND while the host is driving d4 = 0
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'h03;
        @(negedge clk);
        tx_valid = 1'b0;
        wait_rts(ok);
        chk("mid_rst_rts_seen", ok, 1);
        device_clock(4, 1'b1, bits);
        dev_clk = 1'b0;
        repeat (6) @(negedge clk);
        chk("mid_rst_busy", busy, 1);
        chk("mid_rst_data_driven", ps2_data_oe, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_oe_async", {ps2_clk_oe, ps2_data_oe}, 0);
        dev_clk = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_ready", tx_ready, 1);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_err_code", err_code, 0);
        va = '{8'hAA, 11, 1, 1, 0, 1, 1, 2'd0, 11'b11_10101010_0};
        run_vec(va);

        chk("done_err_overlap", both_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
